// File: rtl/axi_wr_arbiter.sv
// AXI write-path scheduler: round-robin AW arbitration plus an AW-order FIFO
// that steers W bursts to the master whose AW was accepted first.
module axi_wr_arbiter #(
  parameter int unsigned N           = 2,
  parameter int unsigned OUTSTANDING = 4
) (
  input  logic                                   clk,
  input  logic                                   rstn,
  input  logic [N-1:0]                           aw_req,
  output logic [N-1:0]                           aw_gnt,
  output logic [$clog2(N)-1:0]                   aw_sel,
  output logic                                   aw_gnt_valid,
  input  logic                                   aw_fire,
  output logic [$clog2(N)-1:0]                   w_sel,
  output logic                                   w_sel_valid,
  input  logic                                   w_last_fire,
  output logic [$clog2(OUTSTANDING+1)-1:0]       outstanding
);

  localparam int unsigned IDX_W = $clog2(N);
  localparam int unsigned CNT_W = $clog2(OUTSTANDING + 1);
  localparam int unsigned PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic {
    S_IDLE,
    S_GRANT
  } state_t;

  state_t             state, state_d;
  logic [IDX_W-1:0]   rr_ptr, rr_ptr_d;
  logic [N-1:0]       aw_gnt_d;
  logic [IDX_W-1:0]   aw_sel_d;
  logic               aw_gnt_valid_d;

  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   cand;

  logic               fifo_full;
  logic               push_c;
  logic               pop_c;

  logic [IDX_W-1:0]   mem [OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr, rd_ptr_d;
  logic [CNT_W-1:0]   count_d;
  logic [IDX_W-1:0]   w_sel_d;
  logic               w_sel_valid_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign fifo_full = (outstanding == CNT_W'(OUTSTANDING));
  assign push_c    = (state == S_GRANT) && aw_fire;
  assign pop_c     = w_last_fire && (outstanding != '0);

  // First requester at or after rr_ptr, wrapping modulo N
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int i = 0; i < int'(N); i++) begin
      cand = IDX_W'((int'(rr_ptr) + i) % int'(N));
      if (!pick_found && aw_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // AW FSM next-state and registered-output values
  always_comb begin
    state_d        = state;
    rr_ptr_d       = rr_ptr;
    aw_gnt_d       = aw_gnt;
    aw_sel_d       = aw_sel;
    aw_gnt_valid_d = aw_gnt_valid;
    case (state)
      S_IDLE: begin
        aw_gnt_d       = '0;
        aw_sel_d       = '0;
        aw_gnt_valid_d = 1'b0;
        if (pick_found && !fifo_full) begin
          state_d        = S_GRANT;
          aw_gnt_d       = {{(N-1){1'b0}}, 1'b1} << pick_idx;
          aw_sel_d       = pick_idx;
          aw_gnt_valid_d = 1'b1;
        end
      end
      S_GRANT: begin
        if (aw_fire) begin
          state_d        = S_IDLE;
          rr_ptr_d       = (aw_sel == IDX_W'(N - 1)) ? '0 : aw_sel + 1'b1;
          aw_gnt_d       = '0;
          aw_sel_d       = '0;
          aw_gnt_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // AW FSM state and grant registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      aw_gnt       <= '0;
      aw_sel       <= '0;
      aw_gnt_valid <= 1'b0;
    end else begin
      state        <= state_d;
      rr_ptr       <= rr_ptr_d;
      aw_gnt       <= aw_gnt_d;
      aw_sel       <= aw_sel_d;
      aw_gnt_valid <= aw_gnt_valid_d;
    end
  end

  // Order FIFO pointer/occupancy update and next head; a push lands in the
  // head slot when the FIFO would otherwise drain to that same slot
  always_comb begin
    wr_ptr_d = push_c ? ptr_inc(wr_ptr) : wr_ptr;
    rd_ptr_d = pop_c  ? ptr_inc(rd_ptr) : rd_ptr;
    count_d  = outstanding;
    if (push_c && !pop_c) begin
      count_d = outstanding + 1'b1;
    end else if (!push_c && pop_c) begin
      count_d = outstanding - 1'b1;
    end
    w_sel_valid_d = (count_d != '0);
    w_sel_d       = '0;
    if (count_d != '0) begin
      w_sel_d = (push_c && (rd_ptr_d == wr_ptr)) ? aw_sel : mem[rd_ptr_d];
    end
  end

  // Order FIFO storage (data only, no reset needed)
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= aw_sel;
    end
  end

  // Order FIFO control and registered W routing outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      outstanding <= '0;
      w_sel       <= '0;
      w_sel_valid <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
      outstanding <= count_d;
      w_sel       <= w_sel_d;
      w_sel_valid <= w_sel_valid_d;
    end
  end

endmodule
